// File: rtl/cic_interp_param_if.sv
// Sample-stream bundle between a baseband source and the CIC interpolator.
// The source owns en/din_valid/din; the filter owns din_ready and the output side.
interface cic_interp_param_if #(
    parameter int INPUT_WIDTH  = 15,
    parameter int OUTPUT_WIDTH = 21
);
    // Handshake: a sample moves on a rising clk edge where din_valid && din_ready;
    // the source keeps din/din_valid stable until that edge, and din_ready never
    // depends on din_valid.
    logic                           en;
    logic                           din_valid;
    logic                           din_ready;
    logic signed [INPUT_WIDTH-1:0]  din;
    logic signed [OUTPUT_WIDTH-1:0] dout;
    logic                           dout_valid;
    logic                           underrun;

    modport master (
        output en,
        output din_valid,
        output din,
        input  din_ready,
        input  dout,
        input  dout_valid,
        input  underrun
    );

    modport slave (
        input  en,
        input  din_valid,
        input  din,
        output din_ready,
        output dout,
        output dout_valid,
        output underrun
    );
endinterface

// File: rtl/cic_interp_param.sv
// N-stage CIC interpolator: low-rate comb chain, zero stuffing, high-rate integrators.
// One input slot every RATE enabled cycles, one output sample per enabled cycle.
module cic_interp_param #(
    parameter int INPUT_WIDTH  = 15,
    parameter int STAGES       = 3,
    parameter int RATE         = 8,
    parameter int DIFF_DELAY   = 1,
    parameter int OUTPUT_WIDTH = 21
) (
    input  logic               clk,
    input  logic               rst,
    cic_interp_param_if.slave  bus
);
    localparam int LOG2_R = $clog2(RATE);
    localparam int LOG2_M = (DIFF_DELAY == 2) ? 1 : 0;
    localparam int IW     = INPUT_WIDTH + STAGES * (LOG2_R + LOG2_M) - LOG2_R;
    localparam int PW     = LOG2_R;
    localparam int CW     = $clog2(STAGES + 1);

    if (STAGES < 1 || STAGES > 6) begin : g_bad_stages
        $error("cic_interp_param: STAGES must be in 1..6");
    end
    if (RATE < 2 || RATE > 256 || (1 << LOG2_R) != RATE) begin : g_bad_rate
        $error("cic_interp_param: RATE must be a power of two in 2..256");
    end
    if (DIFF_DELAY != 1 && DIFF_DELAY != 2) begin : g_bad_delay
        $error("cic_interp_param: DIFF_DELAY must be 1 or 2");
    end
    if (OUTPUT_WIDTH < 1 || OUTPUT_WIDTH > IW) begin : g_bad_width
        $error("cic_interp_param: OUTPUT_WIDTH must be in 1..IW");
    end

    logic [PW-1:0]        phase;
    logic                 primed;
    logic [CW-1:0]        fill;
    logic                 ready;
    logic                 accept;
    logic                 slot;
    logic                 dout_valid_r;
    logic                 underrun_r;
    logic signed [IW-1:0] comb_x [STAGES+1];
    logic signed [IW-1:0] dly    [STAGES][DIFF_DELAY];
    logic signed [IW-1:0] c_out;
    logic signed [IW-1:0] integ  [STAGES];

    assign ready  = bus.en && (phase == '0);
    assign accept = bus.din_valid && ready;
    // Before priming only a real sample opens a slot; afterwards every phase-0 cycle does.
    assign slot   = ready && (primed || bus.din_valid);

    assign bus.din_ready  = ready;
    assign bus.dout       = integ[STAGES-1][IW-1 -: OUTPUT_WIDTH];
    assign bus.dout_valid = dout_valid_r;
    assign bus.underrun   = underrun_r;

    // Comb chain settles within the slot cycle; comb_x[k] is the input of stage k.
    always_comb begin
        comb_x[0] = accept ? IW'(bus.din) : '0;
        for (int k = 0; k < STAGES; k++) begin
            comb_x[k+1] = comb_x[k] - dly[k][DIFF_DELAY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= '0;
            primed       <= 1'b0;
            fill         <= '0;
            dout_valid_r <= 1'b0;
            underrun_r   <= 1'b0;
            c_out        <= '0;
            for (int k = 0; k < STAGES; k++) begin
                integ[k] <= '0;
                for (int j = 0; j < DIFF_DELAY; j++) begin
                    dly[k][j] <= '0;
                end
            end
        end else if (bus.en) begin
            if (primed || accept) begin
                phase <= (phase == PW'(RATE - 1)) ? '0 : phase + PW'(1);
            end
            if (accept) begin
                primed <= 1'b1;
            end

            if (slot) begin
                for (int k = 0; k < STAGES; k++) begin
                    dly[k][0] <= comb_x[k];
                    for (int j = 1; j < DIFF_DELAY; j++) begin
                        dly[k][j] <= dly[k][j-1];
                    end
                end
            end
            if (slot && !bus.din_valid) begin
                underrun_r <= 1'b1;
            end

            c_out    <= slot ? comb_x[STAGES] : '0;
            integ[0] <= integ[0] + c_out;
            for (int k = 1; k < STAGES; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end

            // fill counts enabled edges since the first accept, so output is
            // flagged valid once the first sample has reached the last integrator.
            if (accept && !primed) begin
                fill <= CW'(1);
            end else if (primed && fill != CW'(STAGES)) begin
                fill <= fill + CW'(1);
            end
            dout_valid_r <= (fill == CW'(STAGES));
        end else begin
            dout_valid_r <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cic_interp_param.sv
// Bench for cic_interp_param: two configurations checked cycle by cycle against
// an impulse-response convolution model of the interpolator.
module tb_cic_interp_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cic_interp_param_if #(.INPUT_WIDTH(15), .OUTPUT_WIDTH(21)) bus_a ();
    cic_interp_param_if #(.INPUT_WIDTH(12), .OUTPUT_WIDTH(24)) bus_b ();

    cic_interp_param #(
        .INPUT_WIDTH(15), .STAGES(3), .RATE(8), .DIFF_DELAY(1), .OUTPUT_WIDTH(21)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    cic_interp_param #(
        .INPUT_WIDTH(12), .STAGES(5), .RATE(16), .DIFF_DELAY(2), .OUTPUT_WIDTH(24)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    // model of the selected configuration
    int       sel;
    int       nn, rr, mm, in_w, iw, ow;
    bit       primed_m;
    bit       und_m;
    bit       exp_v;
    longint   h[$];
    longint   u[$];

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s (dut %0d, t=%0t): got %0d expected %0d", tag, sel, $time, got, exp);
        end
    endtask

    // Impulse response of N cascaded boxcars of length R*M.
    function automatic void build_h();
        longint t[$];
        longint acc;
        int     len;
        len = rr * mm;
        h.delete();
        h.push_back(1);
        for (int s = 0; s < nn; s++) begin
            t.delete();
            for (int i = 0; i < h.size() + len - 1; i++) begin
                acc = 0;
                for (int j = 0; j < len; j++) begin
                    if (i - j >= 0 && i - j < h.size()) acc += h[i-j];
                end
                t.push_back(acc);
            end
            h = t;
        end
    endfunction

    // u holds the zero-stuffed high-rate input, one entry per enabled edge since priming.
    function automatic longint exp_dout();
        int     m;
        longint y;
        m = u.size() - 1 - nn;
        y = 0;
        if (m < 0) return 0;
        for (int k = 0; k < h.size() && k <= m; k++) y += h[k] * u[m-k];
        y = (y <<< (64 - iw)) >>> (64 - iw);
        return y >>> (iw - ow);
    endfunction

    function automatic longint settled(input longint x);
        longint g;
        g = 1;
        for (int s = 0; s < nn; s++) g *= rr * mm;
        return (x * (g / rr)) >>> (iw - ow);
    endfunction

    function automatic longint rand_sample();
        int x;
        x = $urandom_range(0, (1 << in_w) - 1);
        return longint'(x) - (longint'(1) <<< (in_w - 1));
    endfunction

    function automatic logic signed [63:0] obs_dout();
        logic signed [63:0] t;
        if (sel == 0) t = bus_a.dout;
        else          t = bus_b.dout;
        return t;
    endfunction

    function automatic logic [2:0] obs_flags();
        if (sel == 0) return {bus_a.din_ready, bus_a.dout_valid, bus_a.underrun};
        return {bus_b.din_ready, bus_b.dout_valid, bus_b.underrun};
    endfunction

    task automatic select(input int s);
        sel = s;
        if (s == 0) begin nn = 3; rr = 8;  mm = 1; in_w = 15; ow = 21; end
        else        begin nn = 5; rr = 16; mm = 2; in_w = 12; ow = 24; end
        iw = in_w + nn * $clog2(rr * mm) - $clog2(rr);
        build_h();
        primed_m = 0; und_m = 0; exp_v = 0;
        u.delete();
    endtask

    task automatic drive(input bit e, input bit v, input longint d);
        if (sel == 0) begin
            bus_a.en = e; bus_a.din_valid = v; bus_a.din = d[14:0];
            bus_b.en = 1'b0; bus_b.din_valid = 1'b0; bus_b.din = '0;
        end else begin
            bus_b.en = e; bus_b.din_valid = v; bus_b.din = d[11:0];
            bus_a.en = 1'b0; bus_a.din_valid = 1'b0; bus_a.din = '0;
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit v, input longint d);
        logic [2:0] f;
        @(negedge clk);
        rst = r;
        drive(e, v, d);
        #1;
        f = obs_flags();
        if (!r) check("din_ready", f[2], e && (!primed_m || (u.size() % rr == 0)));
        @(posedge clk);
        if (r) begin
            primed_m = 0; und_m = 0; exp_v = 0;
            u.delete();
        end else if (e) begin
            if (!primed_m) begin
                if (v) begin
                    primed_m = 1;
                    u.push_back(d);
                end
            end else if (u.size() % rr == 0) begin
                u.push_back(v ? d : 0);
                if (!v) und_m = 1;
            end else begin
                u.push_back(0);
            end
            exp_v = primed_m && (u.size() > nn);
        end else begin
            exp_v = 0;
        end
        #1;
        f = obs_flags();
        check("dout", obs_dout(), exp_dout());
        check("dout_valid", f[1], exp_v);
        check("underrun", f[0], und_m);
    endtask

    task automatic random_run(input int n, input int stall_pct, input int drop_pct);
        for (int i = 0; i < n; i++) begin
            cycle(0, $urandom_range(0, 99) >= stall_pct, $urandom_range(0, 99) >= drop_pct,
                  rand_sample());
        end
    endtask

    initial begin
        longint lv[3];
        lv[0] = 100; lv[1] = -16384; lv[2] = 16383;
        select(0);
        drive(0, 0, 0);

        // reset state and waiting for the first sample
        repeat (2) cycle(1, 1, 0, 0);
        repeat (6) cycle(0, 1, 0, 0);

        // impulse response
        cycle(0, 1, 1, 1);
        repeat (40) cycle(0, 1, 1, 0);

        // DC gain and extremes
        for (int i = 0; i < 3; i++) begin
            repeat (64) cycle(0, 1, 1, lv[i]);
            check("dc_settle", obs_dout(), settled(lv[i]));
        end

        // stall mid-stream
        random_run(30, 0, 0);
        repeat (5) cycle(0, 0, 1, rand_sample());
        random_run(30, 0, 0);

        // underrun: one missed slot, then reset clears the flag
        repeat (2) cycle(1, 1, 0, 0);
        cycle(0, 1, 1, 500);
        random_run(20, 0, 0);
        repeat (8) cycle(0, 1, 0, rand_sample());
        random_run(20, 0, 0);
        cycle(1, 1, 0, 0);

        // reset during a ramp, then an idle wait before repriming
        for (int i = 0; i < 30; i++) cycle(0, 1, 1, longint'(i) * 300 - 4000);
        cycle(1, 1, 1, 0);
        repeat (20) cycle(0, 1, 0, 0);
        for (int i = 0; i < 30; i++) cycle(0, 1, 1, longint'(i) * 300);

        // random soak with stalls, drops and valid at non-slot phases
        random_run(300, 10, 8);

        // wide configuration with truncation
        select(1);
        repeat (2) cycle(1, 1, 0, 0);
        repeat (300) cycle(0, 1, 1, 1);
        check("dc_settle_wide", obs_dout(), settled(1));
        repeat (300) cycle(0, 1, 1, -2048);
        check("dc_settle_wide_neg", obs_dout(), settled(-2048));
        random_run(300, 10, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
